// File: rtl/banco_registrador_mp_if.sv
// Register-file bus: NREAD read ports, one retire write port, one issue port.
// The DUT takes the slave modport; the pipeline front end drives the master side.
interface banco_registrador_mp_if #(
  parameter int XLEN       = 32,
  parameter int AMOUNT     = 16,
  parameter int ADDRESSLEN = 4,
  parameter int NREAD      = 2
);
  logic [NREAD*ADDRESSLEN-1:0] rs;
  logic [NREAD-1:0]            rEn;
  logic [NREAD*XLEN-1:0]       r;
  logic [NREAD-1:0]            rValid;
  logic [NREAD-1:0]            hazard;
  logic                        wEn;
  logic [ADDRESSLEN-1:0]       rd;
  logic [XLEN-1:0]             data;
  logic                        issueEn;
  logic [ADDRESSLEN-1:0]       issueRd;
  logic [AMOUNT-1:0]           busy;

  modport master (
    output rs, rEn, wEn, rd, data, issueEn, issueRd,
    input  r, rValid, hazard, busy
  );
  modport slave (
    input  rs, rEn, wEn, rd, data, issueEn, issueRd,
    output r, rValid, hazard, busy
  );
endinterface

// File: rtl/banco_registrador_mp.sv
// Multi-read-port register file with RAW scoreboard; x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle retire data to matching reads.

module banco_registrador_mp_rport #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDRESSLEN-1:0] rs_i,
  input  logic                  ren_i,
  input  logic                  in_rng_i,
  input  logic                  busy_i,
  input  logic [XLEN-1:0]       rdata_i,
  input  logic                  wen_i,
  input  logic [ADDRESSLEN-1:0] wrd_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic [XLEN-1:0]       r_o,
  output logic                  rvalid_o,
  output logic                  hazard_o
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            fwd;
  logic            zero_rd;
  logic [XLEN-1:0] r_d;

  assign fwd      = BYPASS && wen_i && (wrd_i == rs_i);
  assign zero_rd  = (rs_i == '0) || !in_rng_i;
  assign hazard_o = ren_i && (rs_i != '0) && busy_i && !fwd;
  assign r_d      = zero_rd ? '0 : (fwd ? wdata_i : rdata_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_o      <= '0;
      rvalid_o <= 1'b0;
    end else if (!ren_i || hazard_o) begin
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= 1'b1;
      r_o      <= r_d;
    end
  end
endmodule

module banco_registrador_mp #(
  parameter int XLEN       = 32,
  parameter int AMOUNT     = 16,
  parameter int ADDRESSLEN = 4,
  parameter int NREAD      = 2
) (
  input logic                  clk,
  input logic                  reset,
  banco_registrador_mp_if.slave bus
);
  localparam logic [ADDRESSLEN:0] AMT = AMOUNT[ADDRESSLEN:0];

  logic [AMOUNT-1:0][XLEN-1:0] regs_q, regs_d;
  logic [AMOUNT-1:0]           busy_q, busy_d;
  logic                        rd_in, iss_in, wr_ok, iss_ok;

  logic [NREAD-1:0][XLEN-1:0]  r_w;
  logic [NREAD-1:0]            rv_w, hz_w;

  assign rd_in  = ({1'b0, bus.rd} < AMT);
  assign iss_in = ({1'b0, bus.issueRd} < AMT);
  assign wr_ok  = bus.wEn && rd_in && (bus.rd != '0);
  assign iss_ok = bus.issueEn && iss_in && (bus.issueRd != '0);

  // Issue is applied after retire so a same-cycle reissue keeps the reg busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) regs_d[bus.rd] = bus.data;
    if (bus.wEn && rd_in) busy_d[bus.rd] = 1'b0;
    if (iss_ok) busy_d[bus.issueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NREAD; i++) begin : g_rport
      logic [ADDRESSLEN-1:0] a;
      logic                  in_rng;
      logic [XLEN-1:0]       rdata;
      logic                  bsy;

      assign a      = bus.rs[i*ADDRESSLEN +: ADDRESSLEN];
      assign in_rng = ({1'b0, a} < AMT);
      assign rdata  = in_rng ? regs_q[a] : '0;
      assign bsy    = in_rng && busy_q[a];

      banco_registrador_mp_rport #(
        .XLEN       (XLEN),
        .ADDRESSLEN (ADDRESSLEN)
      ) u_rport (
        .clk      (clk),
        .reset    (reset),
        .rs_i     (a),
        .ren_i    (bus.rEn[i]),
        .in_rng_i (in_rng),
        .busy_i   (bsy),
        .rdata_i  (rdata),
        .wen_i    (bus.wEn),
        .wrd_i    (bus.rd),
        .wdata_i  (bus.data),
        .r_o      (r_w[i]),
        .rvalid_o (rv_w[i]),
        .hazard_o (hz_w[i])
      );
    end
  endgenerate

  assign bus.r      = r_w;
  assign bus.rValid = rv_w;
  assign bus.hazard = hz_w;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_banco_registrador_mp.sv
// Directed bench for banco_registrador_mp (NREAD=2, AMOUNT=16); handles both
// bypass builds through REGFILE_BYPASS_EN.
module tb_banco_registrador_mp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  banco_registrador_mp_if #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4), .NREAD(2)) bus ();

  banco_registrador_mp #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4), .NREAD(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.rs = '0; bus.rEn = '0; bus.wEn = 0; bus.rd = '0; bus.data = '0;
    bus.issueEn = 0; bus.issueRd = '0;

    // 1: reset state, then read of an untouched reg
    tick(); tick();
    chk("rst_r", bus.r, 64'h0);
    chk("rst_rvalid", {62'b0, bus.rValid}, 64'h0);
    chk("rst_busy", {48'b0, bus.busy}, 64'h0);
    reset = 1'b1;
    bus.rEn = 2'b01; bus.rs = {4'd0, 4'd7};
    tick();
    chk("rd_x7_r0", {32'b0, bus.r[31:0]}, 64'h0);
    chk("rd_x7_rv", {62'b0, bus.rValid}, 64'h1);

    // 2: write/read x5, write to x0 ignored
    bus.rEn = 2'b00; bus.wEn = 1; bus.rd = 4'd5; bus.data = 32'hDEADBEEF;
    tick();
    bus.wEn = 0; bus.rEn = 2'b01; bus.rs = {4'd0, 4'd5};
    tick();
    chk("rd_x5_r0", {32'b0, bus.r[31:0]}, 64'hDEADBEEF);
    chk("rd_x5_rv", {62'b0, bus.rValid}, 64'h1);
    bus.rEn = 2'b00; bus.wEn = 1; bus.rd = 4'd0; bus.data = 32'h1234;
    tick();
    bus.wEn = 0; bus.rEn = 2'b01; bus.rs = {4'd0, 4'd0};
    tick();
    chk("rd_x0_r0", {32'b0, bus.r[31:0]}, 64'h0);
    chk("rd_x0_rv", {62'b0, bus.rValid}, 64'h1);

    // 3: issue x3, hazard on read, retire during the read
    bus.rEn = 2'b00; bus.issueEn = 1; bus.issueRd = 4'd3;
    tick();
    bus.issueEn = 0;
    chk("busy_x3", {48'b0, bus.busy}, 64'h0008);
    bus.rEn = 2'b01; bus.rs = {4'd0, 4'd3};
    #1;
    chk("hz_x3", {62'b0, bus.hazard}, 64'h1);
    tick();
    chk("hz_x3_rv", {62'b0, bus.rValid}, 64'h0);
    chk("hz_x3_hold", {32'b0, bus.r[31:0]}, 64'h0);
    bus.wEn = 1; bus.rd = 4'd3; bus.data = 32'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("fwd_hz", {62'b0, bus.hazard}, 64'h0);
    tick();
    bus.wEn = 0;
    chk("fwd_r0", {32'b0, bus.r[31:0]}, 64'h7);
    chk("fwd_rv", {62'b0, bus.rValid}, 64'h1);
    chk("fwd_busy", {48'b0, bus.busy}, 64'h0);
`else
    chk("nofwd_hz", {62'b0, bus.hazard}, 64'h1);
    tick();
    bus.wEn = 0;
    chk("nofwd_rv", {62'b0, bus.rValid}, 64'h0);
    chk("nofwd_busy", {48'b0, bus.busy}, 64'h0);
    tick();
    chk("nofwd_r0", {32'b0, bus.r[31:0]}, 64'h7);
    chk("nofwd_rv2", {62'b0, bus.rValid}, 64'h1);
`endif

    // 4: two ports on same reg, then port1 blocked by busy x6
    bus.rEn = 2'b00; bus.wEn = 1; bus.rd = 4'd4; bus.data = 32'h55;
    tick();
    bus.wEn = 0; bus.issueEn = 1; bus.issueRd = 4'd6;
    tick();
    bus.issueEn = 0; bus.rEn = 2'b11; bus.rs = {4'd4, 4'd4};
    tick();
    chk("dual_r", bus.r, 64'h00000055_00000055);
    chk("dual_rv", {62'b0, bus.rValid}, 64'h3);
    bus.rs = {4'd6, 4'd4};
    #1;
    chk("p1_hz", {62'b0, bus.hazard}, 64'h2);
    tick();
    chk("p1_rv", {62'b0, bus.rValid}, 64'h1);
    chk("p1_r", bus.r, 64'h00000055_00000055);
    bus.rEn = 2'b00; bus.wEn = 1; bus.rd = 4'd6; bus.data = 32'h66;
    tick();
    bus.wEn = 0;
    chk("x6_retired", {48'b0, bus.busy}, 64'h0);

    // 5: issue and retire same reg in one cycle -> stays busy
    bus.issueEn = 1; bus.issueRd = 4'd9; bus.wEn = 1; bus.rd = 4'd9; bus.data = 32'h99;
    tick();
    bus.issueEn = 0; bus.wEn = 0;
    chk("reissue_busy", {48'b0, bus.busy}, 64'h0200);
    bus.wEn = 1; bus.rd = 4'd9;
    tick();
    bus.wEn = 0;

    // 6: async reset mid-read with a busy reg
    bus.issueEn = 1; bus.issueRd = 4'd2;
    tick();
    bus.issueEn = 0;
    chk("busy_x2", {48'b0, bus.busy}, 64'h0004);
    bus.rEn = 2'b01; bus.rs = {4'd0, 4'd5};
    tick();
    chk("pre_rst_r0", {32'b0, bus.r[31:0]}, 64'hDEADBEEF);
    #2 reset = 1'b0;
    #1;
    chk("arst_r", bus.r, 64'h0);
    chk("arst_rv", {62'b0, bus.rValid}, 64'h0);
    chk("arst_busy", {48'b0, bus.busy}, 64'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_x5", {32'b0, bus.r[31:0]}, 64'h0);
    chk("post_rst_rv", {62'b0, bus.rValid}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
